// File: rtl/pacman_sprite_drawer.sv
// Turns a Pac-Man sprite request (25-bit shape, tile x/y) into single-pixel frame-buffer writes.
// It first erases the sprite at its previous tile when the sprite has moved, then draws the new shape.
module pacman_sprite_drawer #(
  parameter logic [2:0] FG_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [24:0] shape,
  input  logic [7:0]  tile_x,
  input  logic [6:0]  tile_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_col, r_row, w_col_nxt, w_row_nxt;
  logic [24:0] r_shape;
  logic [7:0]  r_tile_x, r_prev_x;
  logic [6:0]  r_tile_y, r_prev_y;
  logic        r_prev_valid;

  logic        w_accept, w_prev_upd, w_plot_nxt, w_busy_nxt, w_done_nxt;
  logic        w_in_range, w_last;
  logic [2:0]  w_col_step, w_row_step;
  logic [7:0]  w_px_tile_x;
  logic [6:0]  w_px_tile_y;
  logic [24:0] w_px_shape;
  logic        w_px_erase;
  logic [4:0]  w_bit_idx;
  logic [7:0]  w_pix_x;
  logic [6:0]  w_pix_y;
  logic [2:0]  w_pix_colour;

  assign w_in_range = (tile_x <= 8'd26) && (tile_y <= 7'd23);
  assign w_last     = (r_col == 3'd4) && (r_row == 3'd4);
  assign w_col_step = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
  assign w_row_step = (r_col == 3'd4) ? r_row + 3'd1 : r_row;

  // The pixel written next cycle is derived from the counter values being loaded now.
  assign w_bit_idx    = ({2'd0, w_row_nxt} * 5'd5) + {2'd0, w_col_nxt};
  assign w_pix_x      = (w_px_tile_x * 8'd5) + {5'd0, w_col_nxt};
  assign w_pix_y      = (w_px_tile_y * 7'd5) + {4'd0, w_row_nxt};
  assign w_pix_colour = (w_px_erase || !w_px_shape[w_bit_idx]) ? BG_COLOUR : FG_COLOUR;

  // Next-state, counter and output-strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_accept    = 1'b0;
    w_prev_upd  = 1'b0;
    w_plot_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_px_tile_x = r_tile_x;
    w_px_tile_y = r_tile_y;
    w_px_shape  = r_shape;
    w_px_erase  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_in_range) begin
          w_accept    = 1'b1;
          w_plot_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
          w_col_nxt   = 3'd0;
          w_row_nxt   = 3'd0;
          w_px_shape  = shape;
          if (r_prev_valid && ((r_prev_x != tile_x) || (r_prev_y != tile_y))) begin
            w_state_nxt = S_ERASE;
            w_px_tile_x = r_prev_x;
            w_px_tile_y = r_prev_y;
            w_px_erase  = 1'b1;
          end else begin
            w_state_nxt = S_DRAW;
            w_px_tile_x = tile_x;
            w_px_tile_y = tile_y;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERASE: begin
        w_busy_nxt = 1'b1;
        w_plot_nxt = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DRAW;
          w_col_nxt   = 3'd0;
          w_row_nxt   = 3'd0;
        end else begin
          w_col_nxt   = w_col_step;
          w_row_nxt   = w_row_step;
          w_px_tile_x = r_prev_x;
          w_px_tile_y = r_prev_y;
          w_px_erase  = 1'b1;
        end
      end
      S_DRAW: begin
        w_busy_nxt = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_plot_nxt = 1'b1;
          w_col_nxt  = w_col_step;
          w_row_nxt  = w_row_step;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_prev_upd  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, request latch, previous-tile memory and registered pixel outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_col        <= 3'd0;
      r_row        <= 3'd0;
      r_shape      <= 25'd0;
      r_tile_x     <= 8'd0;
      r_tile_y     <= 7'd0;
      r_prev_x     <= 8'd0;
      r_prev_y     <= 7'd0;
      r_prev_valid <= 1'b0;
      vga_x        <= 8'd0;
      vga_y        <= 7'd0;
      colour       <= 3'd0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      if (w_accept) begin
        r_shape  <= shape;
        r_tile_x <= tile_x;
        r_tile_y <= tile_y;
      end
      if (w_prev_upd) begin
        r_prev_x     <= r_tile_x;
        r_prev_y     <= r_tile_y;
        r_prev_valid <= 1'b1;
      end
      vga_x  <= w_plot_nxt ? w_pix_x : 8'd0;
      vga_y  <= w_plot_nxt ? w_pix_y : 7'd0;
      colour <= w_plot_nxt ? w_pix_colour : 3'd0;
      plot   <= w_plot_nxt;
      busy   <= w_busy_nxt;
      done   <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_pacman_sprite_drawer.sv
// Directed bench for pacman_sprite_drawer: cycle-by-cycle comparison of the packed
// {busy, done, plot, colour, vga_y, vga_x} against a small request/previous-tile model.
module tb_pacman_sprite_drawer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [24:0] shape;
  logic [7:0]  tile_x;
  logic [6:0]  tile_y;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int total = 0;
  int bad   = 0;

  bit         m_pv = 1'b0;
  logic [7:0] m_px = 8'd0;
  logic [6:0] m_py = 7'd0;

  always #5 clock = ~clock;

  pacman_sprite_drawer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .shape   (shape),
    .tile_x  (tile_x),
    .tile_y  (tile_y),
    .vga_x   (vga_x),
    .vga_y   (vga_y),
    .colour  (colour),
    .plot    (plot),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs();
    return {11'd0, busy, done, plot, colour, vga_y, vga_x};
  endfunction

  function automatic logic [31:0] pk(input bit b, input bit d, input bit p,
                                      input logic [2:0] c, input logic [6:0] y, input logic [7:0] x);
    return {11'd0, b, d, p, c, y, x};
  endfunction

  // Issue one valid request and check every cycle through DONE and the following IDLE cycle.
  task automatic do_req(input logic [7:0] tx, input logic [6:0] ty, input logic [24:0] shp,
                        input bit hold, input logic [7:0] ax, input logic [6:0] ay,
                        input logic [24:0] ashp);
    bit erase;
    logic [2:0] ec;
    start  = 1'b1;
    tile_x = tx;
    tile_y = ty;
    shape  = shp;
    @(posedge clock);
    #1;
    if (hold) begin
      tile_x = ax;
      tile_y = ay;
      shape  = ashp;
    end else begin
      start  = 1'b0;
      tile_x = 8'hFF;
      tile_y = 7'h7F;
      shape  = 25'h0F0F0F0;
    end
    erase = m_pv && ((m_px != tx) || (m_py != ty));
    if (erase) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clock);
          check("erase", obs(), pk(1'b1, 1'b0, 1'b1, 3'd0,
                                   7'(int'(m_py) * 5 + r), 8'(int'(m_px) * 5 + c)));
        end
      end
    end
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clock);
        ec = shp[r * 5 + c] ? 3'b110 : 3'b000;
        check("draw", obs(), pk(1'b1, 1'b0, 1'b1, ec,
                                7'(int'(ty) * 5 + r), 8'(int'(tx) * 5 + c)));
      end
    end
    @(negedge clock);
    check("done", obs(), pk(1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 8'd0));
    @(negedge clock);
    check("idle", obs(), 32'd0);
    m_pv = 1'b1;
    m_px = tx;
    m_py = ty;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    shape   = 25'd0;
    tile_x  = 8'd0;
    tile_y  = 7'd0;
    repeat (2) @(negedge clock);
    check("reset", obs(), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset", obs(), 32'd0);

    // 1: first request, no erase, all yellow
    do_req(8'd13, 7'd18, 25'h1FFFFFF, 1'b0, 8'd0, 7'd0, 25'd0);
    // 2: move right: erase old tile then draw black
    do_req(8'd14, 7'd18, 25'h0000000, 1'b0, 8'd0, 7'd0, 25'd0);
    // 3: same tile: no erase, only pixel 0 yellow
    do_req(8'd14, 7'd18, 25'h0000001, 1'b0, 8'd0, 7'd0, 25'd0);

    // 4: out-of-range requests are ignored
    start  = 1'b1;
    shape  = 25'h1FFFFFF;
    tile_x = 8'd27;
    tile_y = 7'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("oor_x", obs(), 32'd0);
    end
    tile_x = 8'd0;
    tile_y = 7'd24;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("oor_y", obs(), 32'd0);
    end
    start = 1'b0;
    @(negedge clock);
    // next valid request must erase (14,18); also the far map corner
    do_req(8'd26, 7'd23, 25'h1234567, 1'b0, 8'd0, 7'd0, 25'd0);

    // 5: start held high with inputs changed after accept
    do_req(8'd0, 7'd0, 25'h1555555, 1'b1, 8'd5, 7'd5, 25'h0AAAAAA);
    do_req(8'd5, 7'd5, 25'h0AAAAAA, 1'b0, 8'd0, 7'd0, 25'd0);

    // 6: reset in cycle N+10 of a request
    start  = 1'b1;
    tile_x = 8'd10;
    tile_y = 7'd10;
    shape  = 25'h000001F;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    check("mid_erase", obs(), pk(1'b1, 1'b0, 1'b1, 3'd0, 7'd26, 8'd29));
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_async", obs(), 32'd0);
    @(negedge clock);
    check("rst_hold", obs(), 32'd0);
    reset_n = 1'b1;
    m_pv = 1'b0;
    @(negedge clock);
    check("rst_idle", obs(), 32'd0);
    do_req(8'd7, 7'd7, 25'h1000000, 1'b0, 8'd0, 7'd0, 25'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
